// File: rtl/fpu_pkg.sv
// Shared FPU types and IEEE operand-class helpers.
// Helpers work on a zero-extended raw operand so one definition serves any EXP_W/MAN_W
// with 1+EXP_W+MAN_W <= RAW_W.
package fpu_pkg;

    typedef enum logic [2:0] {
        FEQ  = 3'd0,
        FLT  = 3'd1,
        FLE  = 3'd2,
        FMIN = 3'd3,
        FMAX = 3'd4
    } fcmp_op_e;

    localparam int RAW_W = 64;
    typedef logic [RAW_W-1:0] fp_raw_t;

    function automatic fp_raw_t exp_mask(input int exp_w);
        return (fp_raw_t'(1) << exp_w) - fp_raw_t'(1);
    endfunction

    function automatic fp_raw_t exp_of(input fp_raw_t v, input int exp_w, input int man_w);
        return (v >> man_w) & exp_mask(exp_w);
    endfunction

    // Zero class includes subnormals, which this unit flushes.
    function automatic logic is_zero(input fp_raw_t v, input int exp_w, input int man_w);
        return exp_of(v, exp_w, man_w) == '0;
    endfunction

    function automatic logic is_nan(input fp_raw_t v, input int exp_w, input int man_w);
        return (exp_of(v, exp_w, man_w) == exp_mask(exp_w)) &&
               ((v & ((fp_raw_t'(1) << man_w) - fp_raw_t'(1))) != '0);
    endfunction

    function automatic logic is_snan(input fp_raw_t v, input int exp_w, input int man_w);
        return is_nan(v, exp_w, man_w) && ((v & (fp_raw_t'(1) << (man_w - 1))) == '0);
    endfunction

    function automatic fp_raw_t canon_nan(input int exp_w, input int man_w);
        return (exp_mask(exp_w) << man_w) | (fp_raw_t'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fcmp_pipe_stage.sv
// One valid/ready register slice; loads whenever empty or draining in the same cycle.
module fcmp_pipe_stage #(
    parameter int PW = 8
) (
    input  logic          sys_clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic          vld_q, vld_d;
    logic [PW-1:0] dat_q, dat_d;

    assign in_ready = !vld_q || out_ready;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (in_ready) begin
            vld_d = in_valid;
            if (in_valid) dat_d = in_data;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = dat_q;

endmodule

// File: rtl/fcmp_unit.sv
// FP compare/select (FEQ/FLT/FLE/FMIN/FMAX): combinational classify and select,
// followed by a LATENCY-deep valid/ready chain carrying {y, nv, tag}.
module fcmp_unit
    import fpu_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 1,
    parameter int TAG_W   = 5,
    localparam int W      = 1 + EXP_W + MAN_W
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [W-1:0]     x1,
    input  logic [W-1:0]     x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic             nv,
    output logic [TAG_W-1:0] out_tag
);

    localparam int      PW    = W + 1 + TAG_W;
    localparam fp_raw_t CANON = canon_nan(EXP_W, MAN_W);

    logic         z1, z2, n1, n2, s1, s2;
    logic [W-1:0] a, b;
    logic         both_zero, any_nan, eq, lt;
    logic [W-1:0] res_y;
    logic         res_nv;

    assign z1 = is_zero(fp_raw_t'(x1), EXP_W, MAN_W);
    assign z2 = is_zero(fp_raw_t'(x2), EXP_W, MAN_W);
    assign n1 = is_nan(fp_raw_t'(x1), EXP_W, MAN_W);
    assign n2 = is_nan(fp_raw_t'(x2), EXP_W, MAN_W);
    assign s1 = is_snan(fp_raw_t'(x1), EXP_W, MAN_W);
    assign s2 = is_snan(fp_raw_t'(x2), EXP_W, MAN_W);

    assign a = z1 ? {x1[W-1], {(W-1){1'b0}}} : x1;
    assign b = z2 ? {x2[W-1], {(W-1){1'b0}}} : x2;

    assign both_zero = z1 && z2;
    assign any_nan   = n1 || n2;
    assign eq        = both_zero || (a == b);

    // Sign-magnitude ordering; negative magnitudes compare reversed.
    always_comb begin
        lt = 1'b0;
        if (both_zero)                lt = 1'b0;
        else if (a[W-1] != b[W-1])    lt = a[W-1];
        else if (a[W-1])              lt = a[W-2:0] > b[W-2:0];
        else                          lt = a[W-2:0] < b[W-2:0];
    end

    always_comb begin
        res_y  = '0;
        res_nv = 1'b1;
        case (op)
            FEQ: begin
                res_y  = {W{eq && !any_nan}};
                res_nv = s1 || s2;
            end
            FLT: begin
                res_y  = {W{lt && !any_nan}};
                res_nv = any_nan;
            end
            FLE: begin
                res_y  = {W{(lt || eq) && !any_nan}};
                res_nv = any_nan;
            end
            FMIN, FMAX: begin
                res_nv = s1 || s2;
                if (n1 && n2)       res_y = CANON[W-1:0];
                else if (n1)        res_y = b;
                else if (n2)        res_y = a;
                else if (both_zero) res_y = {(op == FMIN) ? (a[W-1] | b[W-1]) : (a[W-1] & b[W-1]),
                                             {(W-1){1'b0}}};
                else                res_y = ((op == FMIN) == lt) ? a : b;
            end
            default: ;
        endcase
    end

    // Stage k takes its input from stage k-1 and its ready from stage k+1.
    for (genvar k = 0; k < LATENCY; k++) begin : g_st
        logic          src_vld, dst_rdy, vld, rdy;
        logic [PW-1:0] src_dat, dat;

        if (k == 0) begin : g_head
            assign src_vld = in_valid;
            assign src_dat = {res_y, res_nv, in_tag};
        end else begin : g_body
            assign src_vld = g_st[k-1].vld;
            assign src_dat = g_st[k-1].dat;
        end

        if (k == LATENCY - 1) begin : g_tail
            assign dst_rdy = out_ready;
        end else begin : g_link
            assign dst_rdy = g_st[k+1].rdy;
        end

        fcmp_pipe_stage #(.PW(PW)) u_stage (
            .sys_clk   (sys_clk),
            .rstn      (rstn),
            .in_valid  (src_vld),
            .in_ready  (rdy),
            .in_data   (src_dat),
            .out_valid (vld),
            .out_ready (dst_rdy),
            .out_data  (dat)
        );
    end

    assign in_ready              = g_st[0].rdy;
    assign out_valid             = g_st[LATENCY-1].vld;
    assign {y, nv, out_tag}      = g_st[LATENCY-1].dat;

endmodule

// File: tb/tb_fcmp_unit.sv
// Bench for fcmp_unit (binary32, LATENCY=3): directed vectors, pipeline timing,
// stall, random traffic against a key-ordering reference model, and mid-flight reset.
module tb_fcmp_unit;

    logic        sys_clk = 1'b0;
    logic        rstn, in_valid, in_ready, out_valid, out_ready, nv;
    logic [2:0]  op;
    logic [31:0] x1, x2, y;
    logic [4:0]  in_tag, out_tag;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] y;
        logic        nv;
        logic [4:0]  tag;
    } res_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, y;
        logic        nv;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV] = '{
        '{3'd2, 32'h3F800000, 32'h40000000, 32'hFFFFFFFF, 1'b0},
        '{3'd2, 32'hBF800000, 32'hC0000000, 32'h00000000, 1'b0},
        '{3'd0, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b0},
        '{3'd1, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1},
        '{3'd0, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0},
        '{3'd0, 32'h7F800001, 32'h3F800000, 32'h00000000, 1'b1},
        '{3'd3, 32'h7FC00000, 32'h40400000, 32'h40400000, 1'b0},
        '{3'd4, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0},
        '{3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0},
        '{3'd3, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0},
        '{3'd4, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0},
        '{3'd4, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0},
        '{3'd4, 32'h7F800001, 32'h7F800001, 32'h7FC00000, 1'b1},
        '{3'd6, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b1},
        '{3'd1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0},
        '{3'd2, 32'h3F800000, 32'h3F800000, 32'hFFFFFFFF, 1'b0},
        '{3'd3, 32'hC0000000, 32'h3F800000, 32'hC0000000, 1'b0},
        '{3'd4, 32'h80000001, 32'h00000000, 32'h00000000, 1'b0},
        '{3'd1, 32'hFF800000, 32'hBF800000, 32'hFFFFFFFF, 1'b0},
        '{3'd3, 32'h3F800000, 32'h7F800001, 32'h3F800000, 1'b1}
    };

    fcmp_unit #(.EXP_W(8), .MAN_W(23), .LATENCY(3), .TAG_W(5)) dut (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x1        (x1),
        .x2        (x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .nv        (nv),
        .out_tag   (out_tag)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: order non-NaN values by a signed integer key (-0 and +0 both map to 0).
    function automatic logic [31:0] flush(input logic [31:0] v);
        return (v[30:23] == 8'h00) ? {v[31], 31'h0} : v;
    endfunction

    function automatic bit is_nan_m(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'h0);
    endfunction

    function automatic longint key(input logic [31:0] v);
        longint m = longint'(v[30:0]);
        return v[31] ? -m : m;
    endfunction

    function automatic res_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] t);
        logic [31:0] fa = flush(a);
        logic [31:0] fb = flush(b);
        bit na = is_nan_m(a);
        bit nb = is_nan_m(b);
        bit sa = na && !a[22];
        bit sb = nb && !b[22];
        bit ord = !na && !nb;
        longint ka = key(fa);
        longint kb = key(fb);
        res_t r;
        r.y = 32'h0; r.nv = 1'b1; r.tag = t;
        case (o)
            3'd0: begin r.nv = sa || sb; r.y = (ord && ka == kb)  ? 32'hFFFFFFFF : 32'h0; end
            3'd1: begin r.nv = !ord;     r.y = (ord && ka <  kb)  ? 32'hFFFFFFFF : 32'h0; end
            3'd2: begin r.nv = !ord;     r.y = (ord && ka <= kb)  ? 32'hFFFFFFFF : 32'h0; end
            3'd3, 3'd4: begin
                r.nv = sa || sb;
                if (na && nb)                r.y = 32'h7FC00000;
                else if (na)                 r.y = fb;
                else if (nb)                 r.y = fa;
                else if (ka == 0 && kb == 0) r.y = {(o == 3'd3) ? (fa[31] | fb[31]) : (fa[31] & fb[31]), 31'h0};
                else if (o == 3'd3)          r.y = (ka <= kb) ? fa : fb;
                else                         r.y = (ka >= kb) ? fa : fb;
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 7))
            0: return {r[31], 31'h0};
            1: return {r[31], 8'h00, r[22:0]};
            2: return {r[31], 8'hFF, 1'b1, r[21:0]};
            3: return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            4: return {r[31], 8'hFF, 23'h0};
            5: return {r[31], 8'h7F, r[22:0]};
            default: return r;
        endcase
    endfunction

    task automatic drive_rand(input logic [4:0] t);
        op     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        x1     = rand_val();
        x2     = ($urandom_range(0, 7) == 0) ? x1 : rand_val();
        in_tag = t;
    endtask

    // Issue one op into an idle pipe and wait (bounded) for its result.
    task automatic run_one(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] t, output res_t r, output bit tmo);
        @(posedge sys_clk); #1;
        op = o; x1 = a; x2 = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        tmo = 1'b1;
        r   = '0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                tmo = 1'b0;
                r   = {y, nv, out_tag};
                break;
            end
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; x1 = 32'h0; x2 = 32'h0; in_tag = 5'd0;
        #1 rstn = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || y !== 32'h0 || nv !== 1'b0 || out_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b y=%h nv=%b tag=%0d, want 0 0 0 0",
                     out_valid, y, nv, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        repeat (2) @(posedge sys_clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_directed();
        res_t r;
        bit   tmo;
        for (int i = 0; i < NV; i++) begin
            run_one(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), r, tmo);
            checks++;
            if (tmo || r !== {vecs[i].y, vecs[i].nv, 5'(i)}) begin
                errors++;
                $display("FAIL directed[%0d] op=%0d timeout=%b: got y=%h nv=%b tag=%0d, want y=%h nv=%b tag=%0d",
                         i, vecs[i].op, tmo, r.y, r.nv, r.tag, vecs[i].y, vecs[i].nv, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t exp_q[$];
        res_t e;
        int   sent = 0;
        int   got  = 0;
        out_ready = 1'b1;
        @(posedge sys_clk); #1;
        for (int w = 0; w < 14; w++) begin
            in_valid = (sent < 8);
            if (sent < 8) drive_rand(5'(sent));
            #3;
            checks++;
            if (out_valid !== (w >= 3 && w < 11)) begin
                errors++;
                $display("FAIL b2b_valid window %0d: got %b want %b", w, out_valid, (w >= 3 && w < 11));
            end
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({y, nv, out_tag} !== e) begin
                    errors++;
                    $display("FAIL b2b_result %0d: got y=%h nv=%b tag=%0d, want y=%h nv=%b tag=%0d",
                             got, y, nv, out_tag, e.y, e.nv, e.tag);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, x1, x2, in_tag));
                sent++;
            end
            @(posedge sys_clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 8 || sent != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d results of %0d sent, want 8 of 8", got, sent);
        end
    endtask

    task automatic test_stall();
        res_t        exp_q[$];
        res_t        e;
        logic [31:0] hold_y;
        logic [4:0]  hold_t;
        logic        hold_nv;
        int          acc = 0;
        bit          fresh = 1'b1;
        bit          drained = 1'b0;
        out_ready = 1'b0;
        @(posedge sys_clk); #1;
        for (int w = 0; w < 6; w++) begin
            in_valid = 1'b1;
            if (fresh) drive_rand(5'(10 + acc));
            #3;
            fresh = in_ready;
            if (in_ready) begin
                exp_q.push_back(model(op, x1, x2, in_tag));
                acc++;
            end
            if (w == 3) begin
                hold_y = y; hold_nv = nv; hold_t = out_tag;
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_out_valid: got %b want 1", out_valid);
                end
            end
            if (w >= 3) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready window %0d: got %b want 0", w, in_ready);
                end
            end
            if (w > 3) begin
                checks++;
                if (y !== hold_y || nv !== hold_nv || out_tag !== hold_t) begin
                    errors++;
                    $display("FAIL stall_hold window %0d: got y=%h nv=%b tag=%0d, want y=%h nv=%b tag=%0d",
                             w, y, nv, out_tag, hold_y, hold_nv, hold_t);
                end
            end
            @(posedge sys_clk); #1;
        end
        checks++;
        if (acc != 3) begin
            errors++;
            $display("FAIL stall_accept_count: got %0d want 3", acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 12 && !drained; c++) begin
            #3;
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++;
                if ({y, nv, out_tag} !== e) begin
                    errors++;
                    $display("FAIL stall_drain: got y=%h nv=%b tag=%0d, want y=%h nv=%b tag=%0d",
                             y, nv, out_tag, e.y, e.nv, e.tag);
                end
                drained = (exp_q.size() == 0);
            end
            @(posedge sys_clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain_timeout: %0d results missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        res_t exp_q[$];
        res_t e;
        int   sent = 0;
        int   got  = 0;
        localparam int N = 300;
        for (int c = 0; c < 4000 && (sent < N || exp_q.size() > 0); c++) begin
            in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive_rand(5'(sent));
            #3;
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++;
                if ({y, nv, out_tag} !== e) begin
                    errors++;
                    $display("FAIL random_result %0d: got y=%h nv=%b tag=%0d, want y=%h nv=%b tag=%0d",
                             got, y, nv, out_tag, e.y, e.nv, e.tag);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, x1, x2, in_tag));
                sent++;
            end
            @(posedge sys_clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != N || got != N) begin
            errors++;
            $display("FAIL random_count: sent %0d got %0d, want %0d each", sent, got, N);
        end
    endtask

    task automatic test_reset_midflight();
        res_t r, e;
        bit   tmo;
        out_ready = 1'b0;
        @(posedge sys_clk); #1;
        for (int w = 0; w < 2; w++) begin
            in_valid = 1'b1;
            drive_rand(5'(20 + w));
            @(posedge sys_clk); #1;
        end
        in_valid = 1'b0;
        @(posedge sys_clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_inflight: out_valid=%b want 1", out_valid);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 32'h0 || out_tag !== 5'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_clear: out_valid=%b y=%h tag=%0d in_ready=%b, want 0 0 0 1",
                     out_valid, y, out_tag, in_ready);
        end
        @(posedge sys_clk); #1;
        rstn = 1'b1;
        e = model(3'd4, 32'h40400000, 32'hBF800000, 5'd22);
        run_one(3'd4, 32'h40400000, 32'hBF800000, 5'd22, r, tmo);
        checks++;
        if (tmo || r !== e) begin
            errors++;
            $display("FAIL midrst_first_op timeout=%b: got y=%h nv=%b tag=%0d, want y=%h nv=%b tag=%0d",
                     tmo, r.y, r.nv, r.tag, e.y, e.nv, e.tag);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_extra: out_valid=%b tag=%0d want out_valid 0", out_valid, out_tag);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
